// File: rtl/decode_issue_unit.sv
// decode_issue_unit: fetch/decode pipeline register with a 2-entry
// instruction buffer, load-use bubble insertion, memory-busy hold and
// branch/jump flush. The decode slot and stall line are registered together.
// Optional build macro ISSUE_STATS_EN adds saturating event counters
// (hazard_bubbles, busy_stalls, flush_count, issued_count); ports and
// cycle behaviour are the same with or without it.
// The report input is a simulation observation hook; this synthesizable
// datapath does not act on it.
module decode_issue_unit #(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    fetch_valid,
    input  logic [DATA_WIDTH-1:0]   fetch_instruction,
    input  logic [ADDRESS_BITS-1:0] fetch_PC,
    output logic                    fetch_ready,
    input  logic                    flush,
    input  logic                    mem_busy,
    output logic                    issue_valid,
    output logic [DATA_WIDTH-1:0]   instruction,
    output logic [ADDRESS_BITS-1:0] inst_PC,
    output logic [6:0]              opcode,
    output logic                    stall,
    input  logic                    report
);

    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // What the decode slot does this cycle, in priority order.
    typedef enum logic [2:0] {
        ACT_FLUSH,
        ACT_HOLD,
        ACT_HAZARD,
        ACT_ISSUE,
        ACT_IDLE
    } action_t;

    logic [DATA_WIDTH-1:0]   buf_instr_q [2];
    logic [DATA_WIDTH-1:0]   buf_instr_d [2];
    logic [ADDRESS_BITS-1:0] buf_pc_q [2];
    logic [ADDRESS_BITS-1:0] buf_pc_d [2];
    logic                    rd_ptr_q, rd_ptr_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic [1:0]              count_q, count_d;

    logic                    slot_valid_q, slot_valid_d;
    logic [DATA_WIDTH-1:0]   slot_instr_q, slot_instr_d;
    logic [ADDRESS_BITS-1:0] slot_pc_q, slot_pc_d;
    logic                    stall_q, stall_d;

    logic [DATA_WIDTH-1:0]   head_instr;
    logic [ADDRESS_BITS-1:0] head_pc;
    logic [6:0]              head_op;
    logic                    uses_rs1;
    logic                    uses_rs2;
    logic                    hazard;
    logic                    push;
    logic                    pop;
    action_t                 action;

    assign fetch_ready = (count_q != 2'd2) & ~flush;
    assign push        = fetch_valid & fetch_ready;
    assign pop         = (action == ACT_ISSUE);

    assign head_instr  = buf_instr_q[rd_ptr_q];
    assign head_pc     = buf_pc_q[rd_ptr_q];
    assign head_op     = head_instr[6:0];

    assign issue_valid = slot_valid_q;
    assign instruction = slot_instr_q;
    assign inst_PC     = slot_pc_q;
    assign opcode      = slot_instr_q[6:0];
    assign stall       = stall_q;

    // Load-use detection: a load sitting in the slot whose rd feeds the buffer head.
    always_comb begin
        uses_rs1 = !(head_op == OP_LUI || head_op == OP_AUIPC || head_op == OP_JAL);
        uses_rs2 = (head_op == OP_R_TYPE || head_op == OP_STORE || head_op == OP_BRANCH);
        hazard   = slot_valid_q && (count_q != 2'd0)
                   && (slot_instr_q[6:0] == OP_LOAD)
                   && (slot_instr_q[11:7] != 5'd0)
                   && ((uses_rs1 && (head_instr[19:15] == slot_instr_q[11:7]))
                    || (uses_rs2 && (head_instr[24:20] == slot_instr_q[11:7])));
    end

    // Pick the slot action; flush beats memory busy beats hazard beats issue.
    always_comb begin
        action = ACT_IDLE;
        if (flush)
            action = ACT_FLUSH;
        else if (mem_busy)
            action = ACT_HOLD;
        else if (hazard)
            action = ACT_HAZARD;
        else if (count_q != 2'd0)
            action = ACT_ISSUE;
    end

    // Next state for the buffer and decode slot.
    always_comb begin
        buf_instr_d  = buf_instr_q;
        buf_pc_d     = buf_pc_q;
        rd_ptr_d     = rd_ptr_q ^ pop;
        wr_ptr_d     = wr_ptr_q ^ push;
        count_d      = count_q + 2'(push) - 2'(pop);
        slot_valid_d = slot_valid_q;
        slot_instr_d = slot_instr_q;
        slot_pc_d    = slot_pc_q;
        stall_d      = 1'b0;

        if (push) begin
            buf_instr_d[wr_ptr_q] = fetch_instruction;
            buf_pc_d[wr_ptr_q]    = fetch_PC;
        end

        case (action)
            ACT_FLUSH: begin
                rd_ptr_d     = 1'b0;
                wr_ptr_d     = 1'b0;
                count_d      = 2'd0;
                slot_valid_d = 1'b0;
                slot_instr_d = NOP_INSTR;
                slot_pc_d    = '0;
            end
            ACT_HOLD: begin
                stall_d = 1'b1;
            end
            ACT_HAZARD: begin
                slot_valid_d = 1'b0;
                slot_instr_d = NOP_INSTR;
                slot_pc_d    = '0;
                stall_d      = 1'b1;
            end
            ACT_ISSUE: begin
                slot_valid_d = 1'b1;
                slot_instr_d = head_instr;
                slot_pc_d    = head_pc;
            end
            default: begin
                slot_valid_d = 1'b0;
                slot_instr_d = NOP_INSTR;
                slot_pc_d    = '0;
            end
        endcase
    end

    // Pipeline register; reset discards buffered and slot contents at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buf_instr_q[0] <= NOP_INSTR;
            buf_instr_q[1] <= NOP_INSTR;
            buf_pc_q[0]    <= '0;
            buf_pc_q[1]    <= '0;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            count_q        <= 2'd0;
            slot_valid_q   <= 1'b0;
            slot_instr_q   <= NOP_INSTR;
            slot_pc_q      <= '0;
            stall_q        <= 1'b0;
        end else begin
            buf_instr_q  <= buf_instr_d;
            buf_pc_q     <= buf_pc_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            slot_valid_q <= slot_valid_d;
            slot_instr_q <= slot_instr_d;
            slot_pc_q    <= slot_pc_d;
            stall_q      <= stall_d;
        end
    end

`ifdef ISSUE_STATS_EN
    logic [31:0] hazard_bubbles_q, hazard_bubbles_d;
    logic [31:0] busy_stalls_q, busy_stalls_d;
    logic [31:0] flush_count_q, flush_count_d;
    logic [31:0] issued_count_q, issued_count_d;
    logic        unused_ok;

    // Saturating event counters, one increment per cycle of the matching action.
    always_comb begin
        hazard_bubbles_d = hazard_bubbles_q;
        busy_stalls_d    = busy_stalls_q;
        flush_count_d    = flush_count_q;
        issued_count_d   = issued_count_q;
        if (action == ACT_HAZARD && hazard_bubbles_q != '1)
            hazard_bubbles_d = hazard_bubbles_q + 32'd1;
        if (action == ACT_HOLD && busy_stalls_q != '1)
            busy_stalls_d = busy_stalls_q + 32'd1;
        if (action == ACT_FLUSH && flush_count_q != '1)
            flush_count_d = flush_count_q + 32'd1;
        if (action == ACT_ISSUE && issued_count_q != '1)
            issued_count_d = issued_count_q + 32'd1;
    end

    // Counter registers, cleared with the rest of the pipeline.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hazard_bubbles_q <= '0;
            busy_stalls_q    <= '0;
            flush_count_q    <= '0;
            issued_count_q   <= '0;
        end else begin
            hazard_bubbles_q <= hazard_bubbles_d;
            busy_stalls_q    <= busy_stalls_d;
            flush_count_q    <= flush_count_d;
            issued_count_q   <= issued_count_d;
        end
    end

    assign unused_ok = report ^ (^CORE) ^ (^hazard_bubbles_q) ^ (^busy_stalls_q)
                       ^ (^flush_count_q) ^ (^issued_count_q);
`else
    logic unused_ok;
    assign unused_ok = report ^ (^CORE);
`endif

endmodule

// File: tb/tb_decode_issue_unit.sv
// Self-checking bench for decode_issue_unit: directed scenarios plus a
// randomized run, all compared against a queue-based reference model.
module tb_decode_issue_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic [31:0] fetch_instruction;
    logic [19:0] fetch_PC;
    logic        fetch_ready;
    logic        flush;
    logic        mem_busy;
    logic        issue_valid;
    logic [31:0] instruction;
    logic [19:0] inst_PC;
    logic [6:0]  opcode;
    logic        stall;
    logic        report;

    decode_issue_unit #(.CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20)) dut (
        .clock(clock), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_instruction(fetch_instruction),
        .fetch_PC(fetch_PC), .fetch_ready(fetch_ready),
        .flush(flush), .mem_busy(mem_busy),
        .issue_valid(issue_valid), .instruction(instruction), .inst_PC(inst_PC),
        .opcode(opcode), .stall(stall), .report(report)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] ins;
        logic [19:0] pc;
    } entry_t;

    localparam logic [60:0] RESET_VEC = {1'b0, 32'h0000_0013, 20'h0, 7'h13, 1'b0};

    entry_t      mq[$];
    logic        m_valid;
    logic [31:0] m_ins;
    logic [19:0] m_pc;
    logic        m_stall;
    logic        obs_ready;
    logic        exp_ready;

    function automatic void model_reset();
        mq.delete();
        m_valid = 1'b0;
        m_ins   = 32'h0000_0013;
        m_pc    = 20'h0;
        m_stall = 1'b0;
    endfunction

    function automatic logic [60:0] exp_vec();
        return {m_valid, m_ins, m_pc, m_ins[6:0], m_stall};
    endfunction

    function automatic logic [60:0] obs_vec();
        return {issue_valid, instruction, inst_PC, opcode, stall};
    endfunction

    function automatic bit reads_reg(logic [31:0] ins, logic [4:0] r);
        logic [6:0] op;
        bit r1, r2;
        op = ins[6:0];
        r1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6f);
        r2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
        return (r1 && ins[19:15] == r) || (r2 && ins[24:20] == r);
    endfunction

    function automatic bit load_use(logic [31:0] cand);
        return m_valid && m_ins[6:0] == 7'h03 && m_ins[11:7] != 5'd0
               && reads_reg(cand, m_ins[11:7]);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [7];
        ops = '{7'h03, 7'h33, 7'h13, 7'h37, 7'h23, 7'h63, 7'h6f};
        return {7'b0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'b010,
                5'($urandom_range(0, 3)), ops[$urandom_range(0, 6)]};
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [19:0] pc,
                         input logic fl, input logic mb);
        fetch_valid       = v;
        fetch_instruction = ins;
        fetch_PC          = pc;
        flush             = fl;
        mem_busy          = mb;
    endtask

    // Advance one clock: predict the post-edge state from the model, then sample.
    task automatic cycle();
        bit push;
        entry_t e;
        #1;
        obs_ready = fetch_ready;
        exp_ready = (mq.size() < 2) && !flush;
        push = fetch_valid && exp_ready;
        e.ins = fetch_instruction;
        e.pc  = fetch_PC;
        if (flush) begin
            mq.delete();
            m_valid = 1'b0; m_ins = 32'h13; m_pc = 20'h0; m_stall = 1'b0;
        end else if (mem_busy) begin
            m_stall = 1'b1;
        end else if (mq.size() > 0 && load_use(mq[0].ins)) begin
            m_valid = 1'b0; m_ins = 32'h13; m_pc = 20'h0; m_stall = 1'b1;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_valid = 1'b1; m_ins = e.ins; m_pc = e.pc; m_stall = 1'b0;
            e.ins = fetch_instruction;
            e.pc  = fetch_PC;
        end else begin
            m_valid = 1'b0; m_ins = 32'h13; m_pc = 20'h0; m_stall = 1'b0;
        end
        if (push) mq.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        report = 1'b0;
        drive(1'b0, 32'h0, 20'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        n_cmp++;
        if (obs_vec() !== RESET_VEC) begin
            n_bad++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", obs_vec(), RESET_VEC);
        end
        reset = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (fetch_ready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL reset_ready: got %b expected 1", fetch_ready);
        end
    endtask

    task automatic test_first_issue();
        drive(1'b1, 32'h0050_0093, 20'h4, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 32'h0, 20'h0, 1'b0, 1'b0);
        cycle();
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("[TB] FAIL first_issue_model: got %h expected %h", obs_vec(), exp_vec());
        end
        n_cmp++;
        if ({issue_valid, opcode, inst_PC, stall} !== {1'b1, 7'b0010011, 20'h4, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL first_issue: got v=%b op=%b pc=%h st=%b expected v=1 op=0010011 pc=4 st=0",
                     issue_valid, opcode, inst_PC, stall);
        end
    endtask

    task automatic test_load_use();
        logic [31:0] want_ins [4];
        logic        want_stall [4];
        want_ins   = '{32'h0001_2283, 32'h0000_0013, 32'h0072_8333, 32'h0000_0013};
        want_stall = '{1'b0, 1'b1, 1'b0, 1'b0};
        drive(1'b1, 32'h0001_2283, 20'h8, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 32'h0072_8333, 20'hC, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            drive(1'b0, 32'h0, 20'h0, 1'b0, 1'b0);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("[TB] FAIL load_use_model[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
            n_cmp++;
            if (instruction !== want_ins[i] || stall !== want_stall[i]) begin
                n_bad++;
                $display("[TB] FAIL load_use[%0d]: got ins=%h st=%b expected ins=%h st=%b",
                         i, instruction, stall, want_ins[i], want_stall[i]);
            end
        end
    endtask

    task automatic test_no_hazard();
        logic [31:0] pairs [4];
        int stalls;
        pairs = '{32'h0001_2003, 32'h0010_0333, 32'h0001_2283, 32'h0000_12b7};
        for (int p = 0; p < 2; p++) begin
            stalls = 0;
            drive(1'b1, pairs[2*p], 20'h20, 1'b0, 1'b0);
            cycle();
            drive(1'b1, pairs[2*p+1], 20'h24, 1'b0, 1'b0);
            for (int i = 0; i < 3; i++) begin
                cycle();
                drive(1'b0, 32'h0, 20'h0, 1'b0, 1'b0);
                if (stall === 1'b1) stalls++;
                if (i == 1) begin
                    n_cmp++;
                    if (issue_valid !== 1'b1 || instruction !== pairs[2*p+1]) begin
                        n_bad++;
                        $display("[TB] FAIL no_hazard_issue[%0d]: got v=%b ins=%h expected v=1 ins=%h",
                                 p, issue_valid, instruction, pairs[2*p+1]);
                    end
                end
                n_cmp++;
                if (obs_vec() !== exp_vec()) begin
                    n_bad++;
                    $display("[TB] FAIL no_hazard_model[%0d]: got %h expected %h", p, obs_vec(), exp_vec());
                end
            end
            n_cmp++;
            if (stalls !== 0) begin
                n_bad++;
                $display("[TB] FAIL no_hazard_stalls[%0d]: got %0d expected 0", p, stalls);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [19:0] seen [$];
        drive(1'b1, 32'h0010_0093, 20'h100, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 32'h0, 20'h0, 1'b0, 1'b0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h0010_0093 + 32'(i << 7), 20'h104 + 20'(4 * i), 1'b0, 1'b1);
            cycle();
            n_cmp++;
            if (obs_ready !== exp_ready || (i >= 2 && obs_ready !== 1'b0)) begin
                n_bad++;
                $display("[TB] FAIL bp_ready[%0d]: got %b expected %b", i, obs_ready, exp_ready);
            end
            n_cmp++;
            if (stall !== 1'b1 || inst_PC !== 20'h100 || obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("[TB] FAIL bp_hold[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        drive(1'b0, 32'h0, 20'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (issue_valid === 1'b1) seen.push_back(inst_PC);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("[TB] FAIL bp_drain_model[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (seen.size() != 2 || seen[0] !== 20'h104 || seen[1] !== 20'h108) begin
            n_bad++;
            $display("[TB] FAIL bp_order: got %0d issued expected 2 (104,108)", seen.size());
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h0020_0113, 20'h200, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 32'h0030_0193, 20'h204, 1'b0, 1'b1);
        cycle();
        drive(1'b1, 32'h0040_0213, 20'h208, 1'b0, 1'b1);
        cycle();
        drive(1'b1, 32'h0050_0293, 20'h20C, 1'b1, 1'b1);
        cycle();
        n_cmp++;
        if (obs_ready !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL flush_ready: got %b expected 0", obs_ready);
        end
        n_cmp++;
        if (issue_valid !== 1'b0 || stall !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("[TB] FAIL flush_slot: got %h expected %h", obs_vec(), exp_vec());
        end
        drive(1'b0, 32'h0, 20'h0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_cmp++;
            if (issue_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("[TB] FAIL flush_drop[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h0060_0313, 20'h300, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 32'h0070_0393, 20'h304, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 32'h0, 20'h0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (obs_vec() !== RESET_VEC || fetch_ready !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL async_reset: got %h rdy=%b expected %h rdy=1",
                     obs_vec(), fetch_ready, RESET_VEC);
        end
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        @(posedge clock);
        #1;
        cycle();
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("[TB] FAIL async_reset_after: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, rand_instr(), 20'($urandom), 
                  $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0);
            cycle();
            n_cmp++;
            if (obs_ready !== exp_ready) begin
                n_bad++;
                $display("[TB] FAIL random_ready[%0d]: got %b expected %b", i, obs_ready, exp_ready);
            end
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("[TB] FAIL random_slot[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_issue();
        test_load_use();
        test_no_hazard();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
